clark_tr_p: RTL and testbench

Parametrised Clarke transform, the successor to the fixed 16-bit FOC Clarke stage. Converts phase currents (ia, ib, ic) into stationary-frame (ialpha, ibeta).
- Adds configurable width, two-sample or three-sample input mode, and two output scalings.
- Adds round/saturate with a flag, a channel tag for multiplexed motors, and valid/ready backpressure.
- Sits between the ADC current-sense front end and the Park transform.

---
 rtl/foc_pkg.sv | 14 +
 rtl/sat_round.sv | 41 ++++
 rtl/clark_tr_p.sv | 113 +++++++++++
 tb/tb_clark_tr_p.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/foc_pkg.sv
// Shared constants for the FOC transform stages: Q-format coefficients and
// the intermediate product width used by the Clarke pipeline.
package foc_pkg;

   localparam int FRAC        = 14;
   localparam int K_SQRT3     = 28378;  // round(sqrt(3)   * 2^14)
   localparam int K_INV3      = 5461;   // round(1/3       * 2^14)
   localparam int K_INV_SQRT3 = 9459;   // round(1/sqrt(3) * 2^14)

   function automatic int prod_w(input int iw, input int frac);
      return iw + 2 + frac + 1;
   endfunction

endpackage

// File: rtl/sat_round.sv
// Round-half-up of a Q(FRAC) product followed by a symmetric clamp to OUT_W
// bits; sat_o flags that the clamp was applied.
module sat_round #(
   parameter int IN_W  = 33,
   parameter int OUT_W = 16,
   parameter int FRAC  = 14
) (
   input  logic signed [IN_W-1:0]  p_i,
   output logic signed [OUT_W-1:0] r_o,
   output logic                    sat_o
);

   localparam int RW = IN_W + 1 - FRAC;
   localparam logic signed [IN_W:0]    HALF  = (IN_W+1)'(2 ** (FRAC-1));
   localparam logic signed [RW-1:0]    MAXR  = RW'((2 ** (OUT_W-1)) - 1);
   localparam logic signed [RW-1:0]    MINR  = -MAXR;
   localparam logic signed [OUT_W-1:0] MAXO  = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] MINO  = -MAXO;

   logic signed [IN_W:0] p_rnd;
   logic signed [IN_W:0] p_shr;
   logic signed [RW-1:0] r;

   // One extra bit of headroom so adding the half-LSB cannot wrap.
   assign p_rnd = {p_i[IN_W-1], p_i} + HALF;
   assign p_shr = p_rnd >>> FRAC;
   assign r     = p_shr[RW-1:0];

   always_comb begin
      r_o   = r[OUT_W-1:0];
      sat_o = 1'b0;
      if (r > MAXR) begin
         r_o   = MAXO;
         sat_o = 1'b1;
      end else if (r < MINR) begin
         r_o   = MINO;
         sat_o = 1'b1;
      end
   end

endmodule

// File: rtl/clark_tr_p.sv
// Parametrised Clarke transform: 3-stage pipeline (sum/diff, constant
// multiply, round+saturate) with valid/ready backpressure and a channel tag.
module clark_tr_p
   import foc_pkg::*;
#(
   parameter int IW        = 16,
   parameter int OW        = 16,
   parameter int CHW       = 1,
   parameter bit TWO_PHASE = 1'b0,
   parameter bit AMP_INV   = 1'b0,
   parameter int FRAC      = foc_pkg::FRAC
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_valid,
   output logic                 i_rdy,
   input  logic [CHW-1:0]       i_ch,
   input  logic signed [IW-1:0] i_ia,
   input  logic signed [IW-1:0] i_ib,
   input  logic signed [IW-1:0] i_ic,
   output logic                 o_valid,
   input  logic                 o_rdy,
   output logic [CHW-1:0]       o_ch,
   output logic signed [OW-1:0] o_ialpha,
   output logic signed [OW-1:0] o_ibeta,
   output logic                 o_sat
);

   localparam int SW = IW + 2;
   localparam int PW = prod_w(IW, FRAC);
   localparam logic signed [PW-1:0] K_BETA  = AMP_INV ? PW'(K_INV_SQRT3) : PW'(K_SQRT3);
   localparam logic signed [PW-1:0] K_ALPHA = PW'(K_INV3);

   logic adv;

   logic                 v1_q, v2_q, v3_q;
   logic [CHW-1:0]       ch1_q, ch2_q, ch3_q;
   logic signed [SW-1:0] s_q, d_q;
   logic signed [PW-1:0] ap_q, bp_q;
   logic signed [OW-1:0] alpha_q, beta_q;
   logic                 sat_q;

   logic signed [SW-1:0] a_x, b_x, c_x, s_d, d_d;
   logic signed [PW-1:0] s_ext, d_ext, ap_d, bp_d;
   logic signed [OW-1:0] alpha_d, beta_d;
   logic                 sat_a, sat_b;

   // Every stage moves together; a stalled output freezes the whole pipe.
   assign adv   = ~v3_q | o_rdy;
   assign i_rdy = adv;

   assign a_x = {{2{i_ia[IW-1]}}, i_ia};
   assign b_x = {{2{i_ib[IW-1]}}, i_ib};
   assign c_x = TWO_PHASE ? -(a_x + b_x) : {{2{i_ic[IW-1]}}, i_ic};
   assign s_d = (a_x <<< 1) - b_x - c_x;
   assign d_d = b_x - c_x;

   assign s_ext = {{(PW-SW){s_q[SW-1]}}, s_q};
   assign d_ext = {{(PW-SW){d_q[SW-1]}}, d_q};
   assign ap_d  = AMP_INV ? (s_ext * K_ALPHA) : (s_ext <<< FRAC);
   assign bp_d  = d_ext * K_BETA;

   sat_round #(.IN_W(PW), .OUT_W(OW), .FRAC(FRAC)) u_sr_alpha (
      .p_i   (ap_q),
      .r_o   (alpha_d),
      .sat_o (sat_a)
   );

   sat_round #(.IN_W(PW), .OUT_W(OW), .FRAC(FRAC)) u_sr_beta (
      .p_i   (bp_q),
      .r_o   (beta_d),
      .sat_o (sat_b)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         ch1_q   <= '0;
         ch2_q   <= '0;
         ch3_q   <= '0;
         s_q     <= '0;
         d_q     <= '0;
         ap_q    <= '0;
         bp_q    <= '0;
         alpha_q <= '0;
         beta_q  <= '0;
         sat_q   <= 1'b0;
      end else if (adv) begin
         v1_q    <= i_valid;
         ch1_q   <= i_ch;
         s_q     <= s_d;
         d_q     <= d_d;
         v2_q    <= v1_q;
         ch2_q   <= ch1_q;
         ap_q    <= ap_d;
         bp_q    <= bp_d;
         v3_q    <= v2_q;
         ch3_q   <= ch2_q;
         alpha_q <= alpha_d;
         beta_q  <= beta_d;
         sat_q   <= v2_q & (sat_a | sat_b);
      end
   end

   assign o_valid  = v3_q;
   assign o_ch     = ch3_q;
   assign o_ialpha = alpha_q;
   assign o_ibeta  = beta_q;
   assign o_sat    = sat_q;

endmodule

// File: tb/tb_clark_tr_p.sv
// Directed bench for clark_tr_p: four parameterisations share one stimulus,
// table vectors per configuration, then a backpressured stream and reset.
module tb_clark_tr_p;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic i_valid = 1'b0;
   logic o_rdy = 1'b1;
   logic [0:0] i_ch = '0;
   logic signed [15:0] i_ia = '0, i_ib = '0, i_ic = '0;

   always #5 clk = ~clk;

   logic       ir0, ir1, ir2, ir3;
   logic       ov0, ov1, ov2, ov3;
   logic [0:0] oc0, oc1, oc2, oc3;
   logic signed [15:0] oa0, ob0, oa1, ob1, oa2, ob2;
   logic signed [13:0] oa3, ob3;
   logic       os0, os1, os2, os3;

   clark_tr_p u0 (.clk(clk), .rst(rst), .i_valid(i_valid), .i_rdy(ir0), .i_ch(i_ch),
      .i_ia(i_ia), .i_ib(i_ib), .i_ic(i_ic), .o_valid(ov0), .o_rdy(o_rdy), .o_ch(oc0),
      .o_ialpha(oa0), .o_ibeta(ob0), .o_sat(os0));
   clark_tr_p #(.AMP_INV(1'b1)) u1 (.clk(clk), .rst(rst), .i_valid(i_valid), .i_rdy(ir1),
      .i_ch(i_ch), .i_ia(i_ia), .i_ib(i_ib), .i_ic(i_ic), .o_valid(ov1), .o_rdy(o_rdy),
      .o_ch(oc1), .o_ialpha(oa1), .o_ibeta(ob1), .o_sat(os1));
   clark_tr_p #(.TWO_PHASE(1'b1)) u2 (.clk(clk), .rst(rst), .i_valid(i_valid), .i_rdy(ir2),
      .i_ch(i_ch), .i_ia(i_ia), .i_ib(i_ib), .i_ic(i_ic), .o_valid(ov2), .o_rdy(o_rdy),
      .o_ch(oc2), .o_ialpha(oa2), .o_ibeta(ob2), .o_sat(os2));
   clark_tr_p #(.OW(14)) u3 (.clk(clk), .rst(rst), .i_valid(i_valid), .i_rdy(ir3),
      .i_ch(i_ch), .i_ia(i_ia), .i_ib(i_ib), .i_ic(i_ic), .o_valid(ov3), .o_rdy(o_rdy),
      .o_ch(oc3), .o_ialpha(oa3), .o_ibeta(ob3), .o_sat(os3));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Selected instance outputs, widened for comparison.
   task automatic get_out(input int idx, output logic v, output longint a,
                          output longint b, output logic s);
      case (idx)
         0: begin v = ov0; a = oa0; b = ob0; s = os0; end
         1: begin v = ov1; a = oa1; b = ob1; s = os1; end
         2: begin v = ov2; a = oa2; b = ob2; s = os2; end
         default: begin v = ov3; a = oa3; b = ob3; s = os3; end
      endcase
   endtask

   typedef struct {
      int inst;
      int ia, ib, ic;
      int ea, eb;
      bit es;
   } vec_t;

   typedef struct {
      longint a, b;
      bit s;
      bit [0:0] ch;
   } exp_t;

   // Reference: round-half-up of p/2^14 then symmetric clamp.
   function automatic longint rsat(input longint p, input int ow, output bit s);
      longint r, m;
      r = (p + 8192) >>> 14;
      m = (longint'(1) <<< (ow - 1)) - 1;
      s = 1'b0;
      if (r > m) begin r = m; s = 1'b1; end
      else if (r < -m) begin r = -m; s = 1'b1; end
      return r;
   endfunction

   function automatic exp_t legacy_model(input int a, input int b, input int c, input bit [0:0] ch);
      exp_t e;
      bit sa, sb;
      longint s, d;
      s = 2 * longint'(a) - b - c;
      d = longint'(b) - c;
      e.a = rsat(s * 16384, 16, sa);
      e.b = rsat(d * 28378, 16, sb);
      e.s = sa | sb;
      e.ch = ch;
      return e;
   endfunction

   vec_t vecs[9];
   exp_t q[$];

   initial begin
      logic v, s;
      longint a, b;

      vecs[0] = '{0, 1000, -500, -500, 3000, 0, 0};
      vecs[1] = '{0, 0, 1000, -1000, 0, 3464, 0};
      vecs[2] = '{0, 0, -1000, 1000, 0, -3464, 0};
      vecs[3] = '{1, 1000, -500, -500, 1000, 0, 0};
      vecs[4] = '{1, 0, 1000, -1000, 0, 1155, 0};
      vecs[5] = '{2, 1000, -500, 12345, 3000, 0, 0};
      vecs[6] = '{2, 0, 1000, 12345, 0, 3464, 0};
      vecs[7] = '{3, 8191, -8191, -8191, 8191, 0, 1};
      vecs[8] = '{3, -8191, 8191, 8191, -8191, 0, 1};

      repeat (2) @(negedge clk);
      chk("reset_o_valid", longint'(ov0), 0);
      chk("reset_i_rdy", longint'(ir0), 1);
      chk("reset_alpha", oa0, 0);
      chk("reset_sat", longint'(os0), 0);
      rst = 1'b0;

      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         i_ia = 16'(vecs[k].ia); i_ib = 16'(vecs[k].ib); i_ic = 16'(vecs[k].ic);
         i_valid = 1'b1; o_rdy = 1'b1;
         @(negedge clk);
         i_valid = 1'b0;
         @(negedge clk);
         get_out(vecs[k].inst, v, a, b, s);
         chk($sformatf("vec%0d_latency", k), longint'(v), 0);
         @(negedge clk);
         get_out(vecs[k].inst, v, a, b, s);
         chk($sformatf("vec%0d_valid", k), longint'(v), 1);
         chk($sformatf("vec%0d_alpha", k), a, vecs[k].ea);
         chk($sformatf("vec%0d_beta", k), b, vecs[k].eb);
         chk($sformatf("vec%0d_sat", k), longint'(s), longint'(vecs[k].es));
         $display("vec %0d inst=%0d ia=%0d ib=%0d ic=%0d -> alpha=%0d beta=%0d sat=%0d",
                  k, vecs[k].inst, vecs[k].ia, vecs[k].ib, vecs[k].ic, a, b, s);
      end

      // Backpressured stream on the legacy instance with scoreboard.
      begin
         int sent = 0, got = 0, cyc = 0;
         bit have_cur = 0, stall_prev = 0;
         longint ha = 0, hb = 0;
         logic hs = 0;
         logic [0:0] hc = '0;
         exp_t e;
         while (got < 20 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (stall_prev) begin
               chk("hold_valid", longint'(ov0), 1);
               chk("hold_alpha", oa0, ha);
               chk("hold_beta", ob0, hb);
               chk("hold_ch", longint'(oc0), longint'(hc));
               chk("hold_sat", longint'(os0), longint'(hs));
            end
            o_rdy = 1'($urandom_range(0, 1));
            if (!have_cur) begin
               if (sent < 20 && $urandom_range(0, 3) != 0) begin
                  i_ia = 16'($urandom_range(0, 65535));
                  i_ib = 16'($urandom_range(0, 2000) - 1000);
                  i_ic = 16'($urandom_range(0, 2000) - 1000);
                  i_ch = 1'(sent % 2);
                  i_valid = 1'b1;
                  have_cur = 1;
               end else begin
                  i_valid = 1'b0;
               end
            end
            #1;
            if (ov0 && o_rdy) begin
               if (q.size() == 0) begin
                  chk("stream_spurious", 1, 0);
               end else begin
                  e = q.pop_front();
                  chk("stream_alpha", oa0, e.a);
                  chk("stream_beta", ob0, e.b);
                  chk("stream_sat", longint'(os0), longint'(e.s));
                  chk("stream_ch", longint'(oc0), longint'(e.ch));
                  $display("stream out %0d ch=%0d alpha=%0d beta=%0d sat=%0d",
                           got, oc0, oa0, ob0, os0);
               end
               got++;
            end
            stall_prev = ov0 && !o_rdy;
            ha = oa0; hb = ob0; hs = os0; hc = oc0;
            if (i_valid && ir0) begin
               q.push_back(legacy_model(int'(i_ia), int'(i_ib), int'(i_ic), i_ch));
               sent++;
               have_cur = 0;
            end
         end
         chk("stream_count", got, 20);
         @(negedge clk);
         i_valid = 1'b0;
      end

      // Mid-stream reset: stall a full output, then reset between edges.
      o_rdy = 1'b0;
      i_ia = 16'sd1000; i_ib = -16'sd500; i_ic = -16'sd500; i_ch = 1'b1;
      i_valid = 1'b1;
      repeat (5) @(negedge clk);
      i_valid = 1'b0;
      chk("pre_reset_valid", longint'(ov0), 1);
      chk("pre_reset_i_rdy", longint'(ir0), 0);
      #2 rst = 1'b1;
      #1;
      chk("async_reset_valid", longint'(ov0), 0);
      chk("async_reset_i_rdy", longint'(ir0), 1);
      $display("mid-stream reset: o_valid=%0d i_rdy=%0d", ov0, ir0);
      @(negedge clk);
      rst = 1'b0;
      o_rdy = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_reset_no_output", longint'(ov0), 0);
      chk("post_reset_i_rdy", longint'(ir0), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
